// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Read-side consumer of the async FIFO, running in the rd_clk domain. Reads
// bytes with the FIFO's rd/valid/empty handshake and packs LANES consecutive
// bytes into one output word. A word that is still partial is sent out early
// when the FIFO has been idle for TIMEOUT cycles or when flush is pulsed.
//
// Ports
//   rd_clk, rst_n  FIFO read clock, asynchronous active-low reset
//   fifo_empty     FIFO empty flag
//   fifo_valid     fifo_rdata valid, one cycle after an accepted fifo_rd
//   fifo_rdata     FIFO read data (one byte)
//   fifo_rd        read request to the FIFO
//   flush          pulse: send the current partial word now
//   out_data       packed word; the first byte received is in the low lane
//   out_keep       bit i set when lane i holds real data
//   out_valid      output word valid
//   out_ready      downstream accepts the word when out_valid && out_ready
//   word_count     number of words delivered, wraps
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accumulator empty, waiting for the first byte of a word
// FILL  | 0 < acc_cnt < LANES, collecting bytes, idle timer running
// FULL  | accumulator holds a finished word, waiting for the output slot

module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        rd_clk,
  input  logic                        rst_n,
  input  logic                        fifo_empty,
  input  logic                        fifo_valid,
  input  logic [DATA_WIDTH-1:0]       fifo_rdata,
  output logic                        fifo_rd,
  input  logic                        flush,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNT_WIDTH-1:0]        word_count
);

  localparam int AW = $clog2(LANES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LANES_C   = AW'(LANES);
  localparam logic [IW-1:0] TIMEOUT_C = IW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                        state, state_nxt;
  logic [AW-1:0]                 acc_cnt, cnt_inc;
  logic [DATA_WIDTH*LANES-1:0]   acc_data, acc_next;
  logic [LANES-1:0]              keep_next;
  logic [IW-1:0]                 idle_cnt;
  logic                          rd_q;
  logic                          flush_pend;
  logic                          byte_in, complete, flush_req, flush_fire;
  logic                          word_done, slot_free, take;

  // Never more reads outstanding than free lanes, so a byte always has a home.
  assign fifo_rd = !fifo_empty && (state != FULL) &&
                   (({1'b0, acc_cnt} + {{AW{1'b0}}, rd_q}) < {1'b0, LANES_C});

  always_comb begin
    byte_in    = fifo_valid && rd_q && (state != FULL);
    cnt_inc    = acc_cnt + AW'(byte_in);
    complete   = byte_in && (cnt_inc == LANES_C);
    slot_free  = !out_valid || out_ready;
    flush_req  = (state == FILL) && (flush || flush_pend || (idle_cnt == TIMEOUT_C));
    // A partial word is only cut when no byte is in flight or being requested,
    // so a byte already on its way still joins the word being flushed.
    flush_fire = flush_req && !rd_q && !fifo_rd;
    word_done  = complete || flush_fire;
    take       = slot_free && (word_done || (state == FULL));

    // Lanes above the fill level stay zero because acc_data is cleared on take.
    acc_next  = acc_data;
    keep_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (byte_in && (acc_cnt == AW'(i)))
        acc_next[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
      keep_next[i] = (i < int'(cnt_inc));
    end

    state_nxt = state;
    case (state)
      IDLE: begin
        if (complete)
          state_nxt = take ? IDLE : FULL;
        else if (byte_in)
          state_nxt = FILL;
      end
      FILL: begin
        if (word_done)
          state_nxt = take ? IDLE : FULL;
      end
      FULL: begin
        if (take)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      acc_data   <= '0;
      rd_q       <= 1'b0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      state <= state_nxt;
      rd_q  <= fifo_rd;
      if (take) begin
        acc_cnt  <= '0;
        acc_data <= '0;
      end else begin
        acc_cnt  <= cnt_inc;
        acc_data <= acc_next;
      end
      // Remember a flush that could not be honoured yet; a finished word
      // satisfies it.
      flush_pend <= (state == FILL) && !word_done && (flush || flush_pend);
      if (fifo_valid || fifo_rd || (state_nxt != FILL))
        idle_cnt <= '0;
      else if (idle_cnt != TIMEOUT_C)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      word_count <= '0;
    end else begin
      if (take) begin
        out_valid <= 1'b1;
        out_data  <= acc_next;
        out_keep  <= keep_next;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready)
        word_count <= word_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: a FIFO model feeds bytes, a queue-based
// reference model predicts packed words, and a monitor pops and compares them.

module tb_fifo_word_packer;

  localparam int LN = 4;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_valid = 1'b0;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_rd;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] word_count;

  fifo_word_packer #(
    .DATA_WIDTH(8), .LANES(LN), .TIMEOUT(16), .CNT_WIDTH(16)
  ) dut (
    .rd_clk(rd_clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty), .fifo_valid(fifo_valid), .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd), .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .word_count(word_count)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] stage_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int empty_rd_err = 0;
  int hold_err = 0;
  int exp_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: a word is simply the staged bytes, first byte lowest.
  task automatic emit_stage();
    word_t w;
    if (stage_q.size() == 0) return;
    w.data = 32'h0;
    foreach (stage_q[i]) w.data = w.data | (32'(stage_q[i]) << (8 * i));
    w.keep = 4'((1 << stage_q.size()) - 1);
    exp_q.push_back(w);
    exp_total++;
    stage_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
    stage_q.push_back(b);
    if (stage_q.size() == LN) emit_stage();
  endtask

  // One clock: sample the read request mid-cycle, serve it after the edge.
  task automatic tick();
    logic rd_s;
    @(negedge rd_clk);
    rd_s = fifo_rd;
    if (fifo_rd && fifo_empty) empty_rd_err++;
    @(posedge rd_clk);
    #1;
    if (rd_s && fifo_q.size() > 0) begin
      fifo_rdata = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    stage_q.delete();
    exp_total = 0;
    fifo_empty = 1'b1;
    fifo_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name, input int limit, input bit rand_ready);
    int k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Monitor: pops the scoreboard on every completed handshake.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = 32'h0;
  logic [3:0]  prev_keep = 4'h0;
  word_t       mon_e;

  always @(negedge rd_clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid && (out_data !== prev_data || out_keep !== prev_keep))
        hold_err++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got data %h keep %h, required no word", out_data, out_keep);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", 64'(out_data), 64'(mon_e.data));
          check("word_keep", 64'(out_keep), 64'(mon_e.keep));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_keep", 64'(out_keep), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_fifo_rd", 64'(fifo_rd), 64'd0);

    // Two full words with the output always ready.
    do_reset();
    out_ready = 1'b1;
    for (int b = 1; b <= 8; b++) push_byte(8'(b));
    drain("t1", 200, 1'b0);
    check("t1_word_count", 64'(word_count), 64'd2);

    // Back-pressure: one word held, one in the accumulator, rest left in FIFO.
    do_reset();
    out_ready = 1'b0;
    for (int b = 8'h10; b <= 8'h1B; b++) push_byte(8'(b));
    repeat (40) tick();
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_out_data", 64'(out_data), 64'h13121110);
    check("t2_out_keep", 64'(out_keep), 64'hF);
    check("t2_fifo_rd", 64'(fifo_rd), 64'd0);
    check("t2_fifo_left", 64'(fifo_q.size()), 64'd4);
    out_ready = 1'b1;
    drain("t2", 200, 1'b0);
    check("t2_word_count", 64'(word_count), 64'd3);

    // Idle timeout flushes a 3-byte partial word.
    do_reset();
    out_ready = 1'b1;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    emit_stage();
    repeat (10) tick();
    check("t3_no_early_flush", 64'(out_valid), 64'd0);
    drain("t3", 60, 1'b0);
    check("t3_word_count", 64'(word_count), 64'd1);

    // Flush while a read is being issued waits for that byte.
    do_reset();
    out_ready = 1'b1;
    push_byte(8'h55);
    repeat (4) tick();
    push_byte(8'h66);
    flush = 1'b1;
    #1;
    check("t4_rd_with_flush", 64'(fifo_rd), 64'd1);
    tick();
    flush = 1'b0;
    emit_stage();
    drain("t4", 40, 1'b0);

    // Reset in the middle of operation.
    do_reset();
    out_ready = 1'b1;
    for (int b = 8'hA0; b <= 8'hA3; b++) push_byte(8'(b));
    drain("t5a", 100, 1'b0);
    out_ready = 1'b0;
    for (int b = 8'hB0; b <= 8'hB5; b++) push_byte(8'(b));
    repeat (20) tick();
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    clear_model();
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_out_data", 64'(out_data), 64'd0);
    check("t5_rst_out_keep", 64'(out_keep), 64'd0);
    check("t5_rst_word_count", 64'(word_count), 64'd0);
    check("t5_rst_fifo_rd", 64'(fifo_rd), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int b = 8'hC1; b <= 8'hC4; b++) push_byte(8'(b));
    drain("t5", 100, 1'b0);
    check("t5_word_count", 64'(word_count), 64'd1);

    // Flush in IDLE does nothing; then random traffic with random ready.
    do_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (25) tick();
    check("t6_idle_flush_valid", 64'(out_valid), 64'd0);
    check("t6_idle_flush_count", 64'(word_count), 64'd0);
    for (int i = 0; i < 100; i++) begin
      push_byte(8'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain("t6", 2000, 1'b1);
    check("t6_word_count", 64'(word_count), 64'(exp_total));

    check("fifo_rd_while_empty", 64'(empty_rd_err), 64'd0);
    check("out_hold_stable", 64'(hold_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
